// File: rtl/rmon_update_ctrl.sv
// Read-modify-write engine for port-a of the RMON statistics RAM.
// Arbitrates Rx/Tx counter increments and sweeps the RAM to zero after reset or on request.
module rmon_update_ctrl #(
    parameter int unsigned AW = 6,
    parameter int unsigned DW = 32,
    parameter int unsigned IW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          rx_req,
    input  logic [AW-2:0] rx_addr,
    input  logic [IW-1:0] rx_inc,
    output logic          rx_ack,
    input  logic          tx_req,
    input  logic [AW-2:0] tx_addr,
    input  logic [IW-1:0] tx_inc,
    output logic          tx_ack,
    input  logic          clr_all,
    output logic          init_done,
    output logic [AW-1:0] addra,
    output logic [DW-1:0] dina,
    output logic          wea,
    input  logic [DW-1:0] douta
);

    typedef enum logic [2:0] {StClr, StIdle, StRd, StAdd, StWr} state_e;

    localparam logic [AW:0] PtrOne = (AW+1)'(1);

    state_e        state_q, state_d;
    logic [AW:0]   clr_ptr_q, clr_ptr_d;
    logic          sel_q, sel_d;       // source in flight: 0 = Rx, 1 = Tx
    logic          last_q, last_d;     // last served source, same encoding
    logic          clr_pend_q, clr_pend_d;
    logic [IW-1:0] inc_q, inc_d;
    logic [AW-1:0] addra_d;
    logic [DW-1:0] dina_d;
    logic          wea_d, rx_ack_d, tx_ack_d, init_done_d;
    logic          pick_vld, pick_src, start_rd;
    logic [AW-2:0] pick_addr;
    logic [DW-1:0] sum;

    assign sum = douta + {{(DW-IW){1'b0}}, inc_q};

    always_comb begin
        pick_vld = 1'b0;
        pick_src = 1'b0;
        if (state_q == StWr) begin
            // The source being acked still shows its old req in WR, so only the other may chain.
            pick_vld = sel_q ? rx_req : tx_req;
            pick_src = ~sel_q;
        end else if (rx_req && tx_req) begin
            pick_vld = 1'b1;
            pick_src = ~last_q;
        end else begin
            pick_vld = rx_req | tx_req;
            pick_src = tx_req;
        end
        pick_addr = pick_src ? tx_addr : rx_addr;
    end

    always_comb begin
        state_d     = state_q;
        clr_ptr_d   = clr_ptr_q;
        sel_d       = sel_q;
        last_d      = last_q;
        clr_pend_d  = clr_pend_q;
        inc_d       = inc_q;
        addra_d     = addra;
        dina_d      = dina;
        wea_d       = 1'b0;
        rx_ack_d    = 1'b0;
        tx_ack_d    = 1'b0;
        init_done_d = init_done;
        start_rd    = 1'b0;

        unique case (state_q)
            StClr: begin
                if (clr_all) begin
                    clr_ptr_d = '0;
                end else if (clr_ptr_q[AW]) begin
                    init_done_d = 1'b1;
                    state_d     = StIdle;
                end else begin
                    addra_d   = clr_ptr_q[AW-1:0];
                    dina_d    = '0;
                    wea_d     = 1'b1;
                    clr_ptr_d = clr_ptr_q + PtrOne;
                end
            end
            StIdle: begin
                if (clr_all) begin
                    state_d     = StClr;
                    clr_ptr_d   = '0;
                    init_done_d = 1'b0;
                end else if (pick_vld) begin
                    start_rd = 1'b1;
                end
            end
            StRd: begin
                clr_pend_d = clr_pend_q | clr_all;
                state_d    = StAdd;
            end
            StAdd: begin
                clr_pend_d = clr_pend_q | clr_all;
                dina_d     = sum;
                wea_d      = 1'b1;
                rx_ack_d   = ~sel_q;
                tx_ack_d   = sel_q;
                state_d    = StWr;
            end
            StWr: begin
                if (clr_pend_q || clr_all) begin
                    state_d     = StClr;
                    clr_pend_d  = 1'b0;
                    clr_ptr_d   = '0;
                    init_done_d = 1'b0;
                end else if (pick_vld) begin
                    start_rd = 1'b1;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StClr;
        endcase

        if (start_rd) begin
            state_d = StRd;
            sel_d   = pick_src;
            last_d  = pick_src;
            addra_d = {pick_src, pick_addr};
            inc_d   = pick_src ? tx_inc : rx_inc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StClr;
            clr_ptr_q  <= '0;
            sel_q      <= 1'b0;
            last_q     <= 1'b1;
            clr_pend_q <= 1'b0;
            inc_q      <= '0;
            addra      <= '0;
            dina       <= '0;
            wea        <= 1'b0;
            rx_ack     <= 1'b0;
            tx_ack     <= 1'b0;
            init_done  <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_ptr_q  <= clr_ptr_d;
            sel_q      <= sel_d;
            last_q     <= last_d;
            clr_pend_q <= clr_pend_d;
            inc_q      <= inc_d;
            addra      <= addra_d;
            dina       <= dina_d;
            wea        <= wea_d;
            rx_ack     <= rx_ack_d;
            tx_ack     <= tx_ack_d;
            init_done  <= init_done_d;
        end
    end

endmodule

// File: tb/tb_rmon_update_ctrl.sv
// Scoreboard bench for rmon_update_ctrl: a RAM model on port-a, per-source expected-commit
// queues filled at request time and drained by a monitor on every ack.
module tb_rmon_update_ctrl;

    typedef struct packed {
        logic [5:0]  addr;
        logic [31:0] val;
    } sb_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rx_req, tx_req, rx_ack, tx_ack;
    logic [4:0]  rx_addr, tx_addr;
    logic [15:0] rx_inc, tx_inc;
    logic        clr_all, init_done, wea;
    logic [5:0]  addra;
    logic [31:0] dina, douta;

    logic        bd_we;
    logic [5:0]  bd_addr;
    logic [31:0] bd_data;
    logic [31:0] mem [64];
    logic [31:0] ref_mem [64];

    sb_t rx_q[$];
    sb_t tx_q[$];
    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    rmon_update_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_req    (rx_req),
        .rx_addr   (rx_addr),
        .rx_inc    (rx_inc),
        .rx_ack    (rx_ack),
        .tx_req    (tx_req),
        .tx_addr   (tx_addr),
        .tx_inc    (tx_inc),
        .tx_ack    (tx_ack),
        .clr_all   (clr_all),
        .init_done (init_done),
        .addra     (addra),
        .dina      (dina),
        .wea       (wea),
        .douta     (douta)
    );

    // Port-a RAM: registered read, write on wea; bd_* preloads while the engine is idle.
    always @(posedge clk) begin
        if (wea) mem[addra] <= dina;
        else if (bd_we) mem[bd_addr] <= bd_data;
        douta <= mem[addra];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        sb_t e;
        if (rx_ack) begin
            if (rx_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rx_ack unexpected: got ack with no pending Rx update");
            end else begin
                e = rx_q.pop_front();
                check("rx commit addra", 32'(addra), 32'(e.addr));
                check("rx commit dina", dina, e.val);
                check("rx commit wea", 32'(wea), 32'd1);
            end
        end
        if (tx_ack) begin
            if (tx_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL tx_ack unexpected: got ack with no pending Tx update");
            end else begin
                e = tx_q.pop_front();
                check("tx commit addra", 32'(addra), 32'(e.addr));
                check("tx commit dina", dina, e.val);
                check("tx commit wea", 32'(wea), 32'd1);
            end
        end
    end

    task automatic bd_write(input logic [5:0] a, input logic [31:0] d);
        @(negedge clk);
        bd_we = 1'b1;
        bd_addr = a;
        bd_data = d;
        @(negedge clk);
        bd_we = 1'b0;
        ref_mem[a] = d;
    endtask

    task automatic zero_ref();
        for (int i = 0; i < 64; i++) ref_mem[i] = 32'd0;
    endtask

    // Issue one update from a source and hold it until acked; expected value pushed up front.
    task automatic do_req(input bit src, input logic [4:0] a, input logic [15:0] inc,
                          output int lat, output int ack_cyc);
        sb_t e;
        logic [5:0] full;
        bit got;
        @(negedge clk);
        full = {src, a};
        ref_mem[full] = ref_mem[full] + 32'(inc);
        e.addr = full;
        e.val = ref_mem[full];
        if (src) begin
            tx_q.push_back(e);
            tx_req = 1'b1; tx_addr = a; tx_inc = inc;
        end else begin
            rx_q.push_back(e);
            rx_req = 1'b1; rx_addr = a; rx_inc = inc;
        end
        lat = 0;
        ack_cyc = 0;
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            lat++;
            if ((src ? tx_ack : rx_ack) == 1'b1) begin
                got = 1'b1;
                ack_cyc = cyc;
            end
        end
        check(src ? "tx ack arrived" : "rx ack arrived", 32'(got), 32'd1);
        @(posedge clk);
        #1;
        if (src) tx_req = 1'b0;
        else rx_req = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat_rx, lat_tx, c_rx, c_tx, bad, k;
        bit got;
        sb_t e;
        rst_n = 1'b0;
        rx_req = 1'b0; tx_req = 1'b0; clr_all = 1'b0; bd_we = 1'b0;
        rx_addr = '0; tx_addr = '0; rx_inc = '0; tx_inc = '0;
        bd_addr = '0; bd_data = '0;
        zero_ref();

        // Reset values and the power-up clear sweep.
        repeat (2) @(negedge clk);
        check("reset addra", 32'(addra), 32'd0);
        check("reset dina", dina, 32'd0);
        check("reset wea", 32'(wea), 32'd0);
        check("reset rx_ack", 32'(rx_ack), 32'd0);
        check("reset tx_ack", 32'(tx_ack), 32'd0);
        check("reset init_done", 32'(init_done), 32'd0);
        rst_n = 1'b1;
        bad = 0;
        for (int i = 1; i <= 64; i++) begin
            @(negedge clk);
            if (!(wea === 1'b1 && addra === 6'(i - 1) && dina === 32'd0 && init_done === 1'b0))
                bad++;
        end
        check("clear sweep bad cycles", 32'(bad), 32'd0);
        @(negedge clk);
        check("init_done after sweep", 32'(init_done), 32'd1);
        check("wea after sweep", 32'(wea), 32'd0);

        // Simultaneous requests right after reset: Rx wins the first tie.
        fork
            do_req(1'b0, 5'd1, 16'd10, lat_rx, c_rx);
            do_req(1'b1, 5'd1, 16'd20, lat_tx, c_tx);
        join
        check("tie rx latency", 32'(lat_rx), 32'd3);
        check("tie tx ack 3 cycles after rx", 32'(c_tx - c_rx), 32'd3);

        // Lone Rx update: address held through RD/ADD/WR, ack 3 cycles after IDLE.
        bd_write(6'd3, 32'd100);
        @(negedge clk);
        ref_mem[3] = ref_mem[3] + 32'd64;
        e.addr = 6'd3;
        e.val = ref_mem[3];
        rx_q.push_back(e);
        rx_req = 1'b1; rx_addr = 5'd3; rx_inc = 16'd64;
        @(negedge clk);
        check("rd addra", 32'(addra), 32'd3);
        check("rd wea", 32'(wea), 32'd0);
        check("rd no ack", 32'(rx_ack), 32'd0);
        @(negedge clk);
        check("add addra", 32'(addra), 32'd3);
        check("add no ack", 32'(rx_ack), 32'd0);
        @(negedge clk);
        check("wr addra", 32'(addra), 32'd3);
        check("wr ack", 32'(rx_ack), 32'd1);
        @(posedge clk);
        #1 rx_req = 1'b0;
        @(negedge clk);
        check("ram[3] after update", mem[3], 32'd164);

        // Counter wrap in the Tx bank.
        bd_write(6'd40, 32'hFFFF_FFF0);
        do_req(1'b1, 5'd8, 16'd32, lat_tx, c_tx);
        @(negedge clk);
        check("ram[40] wraps", mem[40], 32'h0000_0010);

        // Randomized concurrent traffic from both sources.
        fork
            for (int n = 0; n < 40; n++) begin
                int l, c;
                repeat ($urandom_range(0, 3)) @(negedge clk);
                do_req(1'b0, 5'($urandom_range(0, 31)), 16'($urandom_range(0, 65535)), l, c);
            end
            for (int n = 0; n < 40; n++) begin
                int l, c;
                repeat ($urandom_range(0, 3)) @(negedge clk);
                do_req(1'b1, 5'($urandom_range(0, 31)), 16'($urandom_range(0, 65535)), l, c);
            end
        join
        @(negedge clk);
        for (int i = 0; i < 64; i++) check($sformatf("ram[%0d] after traffic", i), mem[i], ref_mem[i]);

        // Clear request during ADD: in-flight update acks, then a full sweep.
        @(negedge clk);
        ref_mem[5] = ref_mem[5] + 32'd7;
        e.addr = 6'd5;
        e.val = ref_mem[5];
        rx_q.push_back(e);
        rx_req = 1'b1; rx_addr = 5'd5; rx_inc = 16'd7;
        @(negedge clk);
        @(negedge clk);
        clr_all = 1'b1;
        @(negedge clk);
        clr_all = 1'b0;
        check("clr during add still acks", 32'(rx_ack), 32'd1);
        @(posedge clk);
        #1 rx_req = 1'b0;
        @(negedge clk);
        check("init_done drops for clear", 32'(init_done), 32'd0);
        k = 0;
        for (int i = 1; i <= 100 && k == 0; i++) begin
            @(negedge clk);
            if (init_done) k = i;
        end
        check("clear sweep length", 32'(k), 32'd65);
        zero_ref();
        bad = 0;
        for (int i = 0; i < 64; i++) if (mem[i] !== 32'd0) bad++;
        check("ram nonzero after clear", 32'(bad), 32'd0);

        // Reset during WR, then a request held across the restarted sweep.
        @(negedge clk);
        ref_mem[34] = ref_mem[34] + 32'd5;
        e.addr = 6'd34;
        e.val = ref_mem[34];
        tx_q.push_back(e);
        tx_req = 1'b1; tx_addr = 5'd2; tx_inc = 16'd5;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (tx_ack) got = 1'b1;
        end
        check("reached WR before reset", 32'(got), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("reset in WR wea", 32'(wea), 32'd0);
        check("reset in WR tx_ack", 32'(tx_ack), 32'd0);
        check("reset in WR init_done", 32'(init_done), 32'd0);
        tx_req = 1'b0;
        zero_ref();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        fork
            do_req(1'b0, 5'd9, 16'd3, lat_rx, c_rx);
            begin
                bad = 0;
                for (int i = 1; i <= 64; i++) begin
                    @(negedge clk);
                    if (rx_ack || !wea) bad++;
                end
                check("sweep after reset bad cycles", 32'(bad), 32'd0);
                @(negedge clk);
                check("init_done after reset sweep", 32'(init_done), 32'd1);
                check("no ack at sweep end", 32'(rx_ack), 32'd0);
            end
        join

        @(negedge clk);
        check("rx queue drained", 32'(rx_q.size()), 32'd0);
        check("tx queue drained", 32'(tx_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
